// File: rtl/ir_sequencer_if.sv
// Loader/processor-side bundle for ir_sequencer: program write port, sequencing
// controls and the registered instruction stream toward the SISC core.
interface ir_sequencer_if #(
  parameter int IR_W = 32,
  parameter int AW   = 4
);
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [IR_W-1:0] wr_data;
  logic [AW:0]     prog_len;
  logic            start;
  logic            stall;
  logic [IR_W-1:0] IR;
  logic            ir_valid;
  logic [AW-1:0]   pc;
  logic            busy;
  logic            done;

  modport master (
    output wr_en, wr_addr, wr_data, prog_len, start, stall,
    input  IR, ir_valid, pc, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, prog_len, start, stall,
    output IR, ir_valid, pc, busy, done
  );
endinterface

// File: rtl/ir_sequencer.sv
// Instruction sequencer: presents stored program words on IR for HOLD cycles each,
// stretched by stall, ending on HALT_OP or program end. Optional macro IRSEQ_LOOP_EN wraps to word 0.
module ir_sequencer_chk #(
  parameter int IR_W = 32
) (
  input logic            clk,
  input logic            rst_f,
  input logic [IR_W-1:0] ir,
  input logic            ir_valid,
  input logic            busy,
  input logic            done
);
  a_valid_tracks_busy: assert property (@(posedge clk) disable iff (!rst_f) ir_valid == busy);
  a_nop_when_invalid:  assert property (@(posedge clk) disable iff (!rst_f) !ir_valid |-> (ir == {IR_W{1'b0}}));
  a_done_not_busy:     assert property (@(posedge clk) disable iff (!rst_f) !(done && busy));
endmodule

module ir_sequencer #(
  parameter int       IR_W    = 32,
  parameter int       DEPTH   = 16,
  parameter int       HOLD    = 5,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input logic          CLK,
  input logic          RST_F,
  ir_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] HOLD_RELOAD = CW'(HOLD - 1);
  localparam logic [LW-1:0] DEPTH_L     = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_r;
  logic [IR_W-1:0] mem_r [DEPTH];
  logic [IR_W-1:0] ir_r;
  logic            ir_valid_r;
  logic [AW-1:0]   pc_r;
  logic            busy_r;
  logic            done_r;
  logic [CW-1:0]   cnt_r;
  logic [LW-1:0]   len_r;

  logic [LW-1:0]   len_clamp_s;
  logic [AW-1:0]   pc_next_s;
  logic            is_halt_s;
  logic            is_last_s;
  logic            wr_ok_s;

  // Length clamp and end-of-word decisions
  always_comb begin
    len_clamp_s = bus.prog_len;
    if (bus.prog_len > DEPTH_L) begin
      len_clamp_s = DEPTH_L;
    end else begin
      len_clamp_s = bus.prog_len;
    end
    pc_next_s = pc_r + AW'(1);
    is_halt_s = (ir_r[IR_W-1 -: 4] == HALT_OP);
    is_last_s = ({1'b0, pc_r} == (len_r - LW'(1)));
    wr_ok_s   = bus.wr_en && (state_r != S_ISSUE);
  end

  // Program memory write port; contents survive reset
  always_ff @(posedge CLK) begin
    if (wr_ok_s) begin
      mem_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Sequencing FSM with registered outputs
  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      state_r    <= S_IDLE;
      ir_r       <= {IR_W{1'b0}};
      ir_valid_r <= 1'b0;
      pc_r       <= {AW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      len_r      <= {LW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            if (len_clamp_s == {LW{1'b0}}) begin
              state_r    <= S_DONE;
              ir_r       <= {IR_W{1'b0}};
              ir_valid_r <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
            end else begin
              state_r    <= S_ISSUE;
              len_r      <= len_clamp_s;
              pc_r       <= {AW{1'b0}};
              ir_r       <= mem_r[{AW{1'b0}}];
              ir_valid_r <= 1'b1;
              busy_r     <= 1'b1;
              done_r     <= 1'b0;
              cnt_r      <= HOLD_RELOAD;
            end
          end
        end
        S_ISSUE: begin
          if (!bus.stall) begin
            if (cnt_r != {CW{1'b0}}) begin
              cnt_r <= cnt_r - CW'(1);
            end else if (is_halt_s) begin
              state_r    <= S_DONE;
              ir_r       <= {IR_W{1'b0}};
              ir_valid_r <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
            end else if (is_last_s) begin
`ifdef IRSEQ_LOOP_EN
              pc_r  <= {AW{1'b0}};
              ir_r  <= mem_r[{AW{1'b0}}];
              cnt_r <= HOLD_RELOAD;
`else
              state_r    <= S_DONE;
              ir_r       <= {IR_W{1'b0}};
              ir_valid_r <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
`endif
            end else begin
              pc_r  <= pc_next_s;
              ir_r  <= mem_r[pc_next_s];
              cnt_r <= HOLD_RELOAD;
            end
          end
        end
        default: begin
          state_r    <= S_IDLE;
          ir_r       <= {IR_W{1'b0}};
          ir_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          cnt_r      <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign bus.IR       = ir_r;
  assign bus.ir_valid = ir_valid_r;
  assign bus.pc       = pc_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

  ir_sequencer_chk #(.IR_W(IR_W)) u_chk (
    .clk      (CLK),
    .rst_f    (RST_F),
    .ir       (ir_r),
    .ir_valid (ir_valid_r),
    .busy     (busy_r),
    .done     (done_r)
  );
endmodule

// File: tb/tb_ir_sequencer.sv
// Scoreboard bench for ir_sequencer: a word-level program model fills the expected queue,
// a negedge monitor measures each presented word and compares against it.
module tb_ir_sequencer;
  localparam int IR_W   = 32;
  localparam int DEPTH  = 16;
  localparam int HOLD   = 5;
  localparam int AW     = 4;
  localparam int CAPMAX = 600;
  localparam int PATN   = 1024;

  logic CLK   = 1'b0;
  logic RST_F = 1'b1;

  ir_sequencer_if #(.IR_W(IR_W), .AW(AW)) bus ();

  ir_sequencer #(.IR_W(IR_W), .DEPTH(DEPTH), .HOLD(HOLD), .HALT_OP(4'hF)) dut (
    .CLK   (CLK),
    .RST_F (RST_F),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          pc;
    logic [31:0] ir;
    int          dur;
  } word_t;

  word_t       exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  bit          pat [PATN];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          prev_pc = 0;

  bit          act = 1'b0;
  int          cur_pc;
  int          cur_dur;
  logic [31:0] cur_ir;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Monitor: measure each contiguous word presentation and score it at its end
  always @(negedge CLK) begin : mon
    word_t e;
    if (act && (!bus.ir_valid || int'(bus.pc) != cur_pc || bus.IR !== cur_ir)) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL word_unexpected: got pc=%0d ir=%h dur=%0d, required no word", cur_pc, cur_ir, cur_dur);
      end else begin
        e = exp_q.pop_front();
        if (e.pc != cur_pc || e.ir !== cur_ir || e.dur != cur_dur) begin
          n_fail++;
          $display("FAIL word: got pc=%0d ir=%h dur=%0d, required pc=%0d ir=%h dur=%0d",
                   cur_pc, cur_ir, cur_dur, e.pc, e.ir, e.dur);
        end
      end
      act = 1'b0;
    end
    if (bus.ir_valid === 1'b1) begin
      if (!act) begin
        act     = 1'b1;
        cur_pc  = int'(bus.pc);
        cur_ir  = bus.IR;
        cur_dur = 1;
      end else begin
        cur_dur++;
      end
    end
  end

  // Word-level program model: walk the program, each word lasting HOLD unstalled cycles
  task automatic build(input int lenc, input int cap, output int total, output bit term, output int last_pc);
    int    t;
    int    p;
    int    d;
    int    c;
    bit    ended;
    word_t w;
    t = 0; p = 0;
    term = 1'b0; last_pc = prev_pc; total = cap;
    if (lenc == 0) begin
      term = 1'b1; total = 0;
      return;
    end
    while (t < cap) begin
      d = 0; c = 0;
      while (c < HOLD) begin
        if (t + d >= PATN || !pat[t + d]) c++;
        d++;
      end
      w.pc = p; w.ir = ref_mem[p]; w.dur = (t + d > cap) ? cap - t : d;
      exp_q.push_back(w);
      last_pc = p; t += d; ended = 1'b0;
      if (ref_mem[p][31:28] == 4'hF) ended = 1'b1;
      else if (p == lenc - 1) begin
`ifdef IRSEQ_LOOP_EN
        p = 0;
`else
        ended = 1'b1;
`endif
      end else p++;
      if (ended) begin
        term = (t <= cap);
        if (term) total = t;
        break;
      end
    end
  endtask

  task automatic load(input int a, input logic [31:0] d);
    @(posedge CLK); #1;
    bus.wr_en = 1'b1; bus.wr_addr = a[AW-1:0]; bus.wr_data = d;
    @(posedge CLK); #1;
    bus.wr_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic fill_random(input bit with_halts);
    logic [31:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      if (w[31:28] == 4'hF && !(with_halts && $urandom_range(0, 3) == 0)) w[31:28] = 4'h7;
      load(i, w);
    end
  endtask

  // One sequencing run: stall_pct < 0 keeps the preset stall pattern
  task automatic run(input string name, input int plen, input int stall_pct, input bit intrude, input int reset_at);
    int cap;
    int total;
    int last_pc;
    int lenc;
    int nc;
    bit term;
    if (stall_pct >= 0)
      for (int i = 0; i < PATN; i++) pat[i] = ($urandom_range(0, 99) < stall_pct);
    lenc = (plen > DEPTH) ? DEPTH : plen;
    cap  = (reset_at >= 0) ? reset_at : CAPMAX;
    build(lenc, cap, total, term, last_pc);
    @(posedge CLK); #1;
    bus.prog_len = plen[AW:0]; bus.start = 1'b1;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    check({name, "_t0_busy_done"}, {62'd0, bus.busy, bus.done}, (lenc == 0) ? 64'd1 : 64'd2);
    nc = term ? total : cap;
    for (int t = 0; t < nc; t++) begin
      bus.stall   = pat[t];
      bus.start   = intrude && ($urandom_range(0, 15) == 0);
      bus.wr_en   = intrude && ($urandom_range(0, 7) == 0);
      bus.wr_addr = AW'($urandom_range(0, DEPTH - 1));
      bus.wr_data = $urandom;
      if (intrude && t == 2) begin
        bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = 32'hDEADBEEF; bus.start = 1'b1;
      end
      @(posedge CLK); #1;
    end
    bus.stall = 1'b0; bus.start = 1'b0; bus.wr_en = 1'b0;
    if (term) begin
      check({name, "_end_done"},  {63'd0, bus.done}, 64'd1);
      check({name, "_end_busy"},  {63'd0, bus.busy}, 64'd0);
      check({name, "_end_valid"}, {63'd0, bus.ir_valid}, 64'd0);
      check({name, "_end_ir"},    {32'd0, bus.IR}, 64'd0);
      check({name, "_end_pc"},    {60'd0, bus.pc}, 64'(last_pc));
      prev_pc = last_pc;
    end else begin
      check({name, "_prerst_busy_done"}, {62'd0, bus.busy, bus.done}, 64'd2);
      #1 RST_F = 1'b0;
      #1;
      check({name, "_rst_ir"},   {32'd0, bus.IR}, 64'd0);
      check({name, "_rst_flags"}, {61'd0, bus.busy, bus.ir_valid, bus.done}, 64'd0);
      check({name, "_rst_pc"},   {60'd0, bus.pc}, 64'd0);
      prev_pc = 0;
    end
    @(negedge CLK); #1;
    check({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    if (!term) begin
      @(posedge CLK); #2 RST_F = 1'b1;
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.prog_len = '0; bus.start = 1'b0; bus.stall = 1'b0;
    for (int i = 0; i < PATN; i++) pat[i] = 1'b0;
    #2 RST_F = 1'b0;
    #20;
    check("reset_ir",    {32'd0, bus.IR}, 64'd0);
    check("reset_flags", {61'd0, bus.busy, bus.ir_valid, bus.done}, 64'd0);
    check("reset_pc",    {60'd0, bus.pc}, 64'd0);
    RST_F = 1'b1;

    load(0, 32'h8802000A); load(1, 32'h88030007); load(2, 32'h80231002);
    run("basic", 3, 0, 1'b0, -1);

    load(0, 32'h00000000); load(1, 32'hF0000000); load(2, 32'h8802000A);
    run("halt", 3, 0, 1'b0, -1);

    load(0, 32'h8802000A); load(1, 32'h88030007); load(2, 32'h80231002);
    for (int i = 0; i < PATN; i++) pat[i] = 1'b0;
    pat[1] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b1;
    run("stall", 3, -1, 1'b0, -1);

    run("reset_mid", 3, 0, 1'b0, 7);
    run("after_reset", 3, 0, 1'b0, -1);

    run("loop2", 2, 0, 1'b0, 6 * HOLD);

    run("busy_intrude", 3, 0, 1'b1, -1);
    run("mem_kept", 3, 0, 1'b0, -1);

    run("empty", 0, 0, 1'b0, -1);

    fill_random(1'b0);
    run("clamp", 20, 0, 1'b0, -1);

    for (int r = 0; r < 10; r++) begin
      fill_random(1'b1);
      run($sformatf("rand%0d", r), int'($urandom_range(0, 31)), 20, 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ir_sequencer.md
# ir_sequencer

Parametrised instruction sequencer that replaces hand-timed instruction driving on the SISC processor's `IR` input. A small program memory is loaded through a write port. On `start`, the block presents each stored word on `IR` for a configurable number of clock cycles, and the processor can extend that window with `stall`. Sequencing ends on a halt opcode or at the end of the program. The block sits between the stimulus/loader logic and the processor core, on the same clock and reset as the core.

## Interface
Parameters:
- `IR_W`, 32: instruction width.
- `DEPTH`, 16: program memory words (power of two, ≥2); `AW = $clog2(DEPTH)`.
- `HOLD`, 5: cycles each word is presented (≥1). The processor is multicycle; 5 cycles equals the 50 ns step at a 10 ns clock.
- `HALT_OP`, 4'hF: halt opcode, compared against `IR[IR_W-1:IR_W-4]`.

Ports:
- `CLK`, in, 1: clock, rising edge.
- `RST_F`, in, 1: reset, asynchronous, active-low.
- `wr_en`, in, 1: program write strobe.
- `wr_addr`, in, AW: write address.
- `wr_data`, in, IR_W: write data.
- `prog_len`, in, AW+1: program length in words (0..DEPTH), sampled on `start`.
- `start`, in, 1: begin sequencing (single-cycle pulse or level).
- `stall`, in, 1: freezes the hold counter while high.
- `IR`, out, IR_W: registered instruction to the processor.
- `ir_valid`, out, 1: `IR` carries a program word.
- `pc`, out, AW: index of the word on `IR`.
- `busy`, out, 1: sequencing in progress.
- `done`, out, 1: sequence finished (sticky until the next `start`).

## Operation
Reset (`RST_F`=0, asynchronous): state IDLE, `IR`=0 (NOP), `ir_valid`=0, `pc`=0, `busy`=0, `done`=0, hold counter=0. Memory contents are not cleared.

Writes:
- Accepted only in IDLE or DONE; ignored while `busy`.

States and transitions:
- **IDLE**
  - `start`=1 with `prog_len`=0 → DONE.
  - `start`=1 with `prog_len`≥1 → ISSUE. Latch the length, `pc`=0, `IR`=mem[0], `ir_valid`=1, `busy`=1, counter=HOLD-1.
- **ISSUE**
  - `stall`=1: all state holds.
  - `stall`=0 and counter>0: decrement the counter.
  - `stall`=0 and counter=0:
    - Opcode of `IR` == HALT_OP → DONE.
    - `pc`==len-1 → end of program (see Configuration).
    - Otherwise `pc`+1, `IR`=mem[`pc`+1], counter=HOLD-1.
  - `start` is ignored in ISSUE.
- **DONE**
  - `IR`=0, `ir_valid`=0, `busy`=0, `done`=1; `pc` keeps the last issued index.
  - `start` behaves as in IDLE and clears `done` on the same edge.

Rules:
- The halt word itself is presented for its full HOLD cycles before DONE is entered.
- A `prog_len` value greater than DEPTH is clamped to DEPTH.

## Timing
- `start` sampled at edge k → `IR`=mem[0], `ir_valid`=1, `busy`=1 after edge k.
- Each word is visible for exactly HOLD cycles plus one cycle per stalled cycle.
- N words, no halt, no stall: `busy` lasts N×HOLD cycles; `done` rises on the edge ending the last word.
- `prog_len`=0: `done`=1 after edge k, and `busy` never rises.
- Word switches are glitch-free: `IR` changes only on `CLK` edges, except on reset assertion.
- Reset mid-sequence forces the reset values immediately. After release, a new `start` is required; memory is retained.

## Configuration
- `IRSEQ_LOOP_EN` defined: at end of program, return to `pc`=0, `IR`=mem[0], counter=HOLD-1, stay in ISSUE.
  - Only a HALT_OP word or reset terminates the sequence.
  - `done` never asserts unless a halt word is reached.
- `IRSEQ_LOOP_EN` undefined: end of program → DONE.

## Test plan
- **Basic issue:** load 0x8802000A, 0x88030007, 0x80231002; `prog_len`=3; HOLD=5; pulse `start` → each word on `IR` for exactly 5 cycles with `pc`=0,1,2. `done`=1 and `IR`=0 15 cycles after `start`.
- **Halt:** load 0x00000000, 0xF0000000, 0x8802000A; `prog_len`=3 → 0x00000000 for 5 cycles, then 0xF0000000 for 5 cycles, then DONE. 0x8802000A is never presented.
- **Stall:** basic program; hold `stall`=1 for 3 cycles during word 0 → word 0 visible 8 cycles; total `busy` 18 cycles.
- **Reset mid-operation:** drive `RST_F`=0 while `pc`=1 → `IR`=0, `busy`=0, `ir_valid`=0 without waiting for a clock. Release and `start` → sequence restarts at `pc`=0 with memory intact.
- **Loop:** `prog_len`=2, no halt word.
  - Macro defined: `pc` runs 0,1,0,1… for at least 4 words; `done` stays 0.
  - Macro undefined: `done`=1 after 10 cycles.
- **Protocol edges:**
  - `wr_en` to address 0 with 0xDEADBEEF while `busy` → mem[0] unchanged on the next run.
  - `start` while `busy` → ignored.
  - `prog_len`=0 → `done` one cycle after `start`, `ir_valid` never asserted.
